// File: rtl/param_inst_buffer_pkg.sv
// Shared definitions for the instruction buffer: packet geometry, field
// offsets inside a decoded packet and the default queue/lane widths.
package param_inst_buffer_pkg;

  // Decoded packet width and the position of the branch flag.
  localparam int IB_PKT_W  = 32;
  localparam int IB_BR_BIT = 31;

  // Field layout of a decoded packet (LSB offset and width).
  localparam int FLD_UOP_LSB  = 0;
  localparam int FLD_UOP_W    = 8;
  localparam int FLD_SRC_LSB  = 8;
  localparam int FLD_SRC_W    = 8;
  localparam int FLD_DST_LSB  = 16;
  localparam int FLD_DST_W    = 8;
  localparam int FLD_IMM_LSB  = 24;
  localparam int FLD_IMM_W    = 7;
  localparam int FLD_BR_LSB   = IB_BR_BIT;

  // Default queue geometry.
  localparam int DEF_FETCH_WIDTH    = 8;
  localparam int DEF_DISPATCH_WIDTH = 4;
  localparam int DEF_DEPTH          = 32;

endpackage

// File: rtl/param_inst_buffer_ib_ram.sv
// Instruction buffer storage: DEPTH x PKT_W, multiple write ports and
// combinational read ports. Write addresses are distinct within a cycle
// because the caller compacts lanes into consecutive entries.
module ib_ram #(
  parameter int DEPTH    = 32,
  parameter int PKT_W    = 32,
  parameter int WR_PORTS = 8,
  parameter int RD_PORTS = 4,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [WR_PORTS-1:0]       wrEn,
  input  logic [WR_PORTS*AW-1:0]    wrAddr,
  input  logic [WR_PORTS*PKT_W-1:0] wrData,
  input  logic [RD_PORTS*AW-1:0]    rdAddr,
  output logic [RD_PORTS*PKT_W-1:0] rdData
);

  logic [PKT_W-1:0] mem [DEPTH];

  // Store every enabled write lane at its own address.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wrEn[p]) begin
        mem[wrAddr[p*AW +: AW]] <= wrData[p*PKT_W +: PKT_W];
      end
    end
  end

  // Asynchronous read of each read port.
  always_comb begin
    rdData = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rdData[k*PKT_W +: PKT_W] = mem[rdAddr[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/param_inst_buffer.sv
// Decoded-instruction queue between decode and dispatch. Sparse write lanes
// are compacted into a circular buffer; up to DISPATCH_WIDTH oldest entries
// are presented each cycle and retired when dispatched.
// Handshake: a write is taken only when decodeReady_i=1 and stallFetch_o=0;
// dispatch lanes are valid for the cycle they are shown and are consumed at
// the next rising edge (the backend holds them off with stall_i).
module param_inst_buffer
  import param_inst_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH    = DEF_FETCH_WIDTH,
  parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int PKT_W          = IB_PKT_W,
  parameter int BR_BIT         = IB_BR_BIT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic                              stall_i,
  input  logic                              decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]            decodedVector_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]      decodedPacket_i,
  input  logic [$clog2(DISPATCH_WIDTH):0]   dispWidth_i,
  input  logic                              partialEn_i,
  output logic                              stallFetch_o,
  output logic [DISPATCH_WIDTH-1:0]         dispatchValid_o,
  output logic [DISPATCH_WIDTH*PKT_W-1:0]   decodedPacket_o,
  output logic [$clog2(DISPATCH_WIDTH):0]   branchCount_o,
  output logic [$clog2(DEPTH):0]            occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DISPATCH_WIDTH) + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic                              accept;
  logic [FETCH_WIDTH-1:0]            wrEn;
  logic [FETCH_WIDTH*AW-1:0]         wrAddr;
  logic [CW-1:0]                     wrCount;
  logic [CW-1:0]                     written;
  logic [DISPATCH_WIDTH*AW-1:0]      rdAddr;
  logic [DISPATCH_WIDTH*PKT_W-1:0]   rdData;
  logic [CW-1:0]                     effW;
  logic [CW-1:0]                     nDisp;

  assign stallFetch_o = count > CW'(DEPTH - FETCH_WIDTH);
  assign accept       = decodeReady_i & ~stallFetch_o;
  assign written      = accept ? wrCount : '0;
  assign occupancy_o  = count;

  // Compact valid write lanes into consecutive entries starting at tail.
  always_comb begin
    wrEn    = '0;
    wrAddr  = '0;
    wrCount = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wrAddr[i*AW +: AW] = tail + AW'(wrCount);
      if (decodedVector_i[i]) begin
        wrEn[i] = accept;
        wrCount = wrCount + CW'(1);
      end
    end
  end

  // Dispatch count from the clamped width, stall and partial-group mode.
  always_comb begin
    effW  = (dispWidth_i > DW'(DISPATCH_WIDTH)) ? CW'(DISPATCH_WIDTH) : CW'(dispWidth_i);
    nDisp = '0;
    if (stall_i || (effW == '0)) begin
      nDisp = '0;
    end else if (!partialEn_i) begin
      nDisp = (count >= effW) ? effW : '0;
    end else begin
      nDisp = (count < effW) ? count : effW;
    end
  end

  // Read addresses walk forward from head and wrap with the pointer width.
  always_comb begin
    rdAddr = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      rdAddr[k*AW +: AW] = head + AW'(k);
    end
  end

  // Present the first nDisp entries, zero the rest, count branch flags.
  always_comb begin
    dispatchValid_o = '0;
    decodedPacket_o = '0;
    branchCount_o   = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (CW'(k) < nDisp) begin
        dispatchValid_o[k]               = 1'b1;
        decodedPacket_o[k*PKT_W +: PKT_W] = rdData[k*PKT_W +: PKT_W];
        branchCount_o = branchCount_o + DW'(rdData[k*PKT_W + BR_BIT]);
      end
    end
  end

  // Pointer and count update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(nDisp);
      tail  <= tail + AW'(written);
      count <= count + written - nDisp;
    end
  end

  ib_ram #(
    .DEPTH    (DEPTH),
    .PKT_W    (PKT_W),
    .WR_PORTS (FETCH_WIDTH),
    .RD_PORTS (DISPATCH_WIDTH),
    .AW       (AW)
  ) u_ram (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (decodedPacket_i),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

endmodule

// File: tb/tb_param_inst_buffer.sv
// Directed bench for param_inst_buffer: a cycle-by-cycle vector table with
// hand-computed outputs, then a steady write+dispatch sequence checked
// against an expected-packet queue.
module tb_param_inst_buffer;

  localparam int FW = 8;
  localparam int DWD = 4;
  localparam int PW = 32;

  logic            clk;
  logic            reset;
  logic            flush_i;
  logic            stall_i;
  logic            decodeReady_i;
  logic [FW-1:0]   decodedVector_i;
  logic [FW*PW-1:0] decodedPacket_i;
  logic [2:0]      dispWidth_i;
  logic            partialEn_i;
  logic            stallFetch_o;
  logic [DWD-1:0]  dispatchValid_o;
  logic [DWD*PW-1:0] decodedPacket_o;
  logic [2:0]      branchCount_o;
  logic [5:0]      occupancy_o;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] exp_q[$];

  param_inst_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .stall_i         (stall_i),
    .decodeReady_i   (decodeReady_i),
    .decodedVector_i (decodedVector_i),
    .decodedPacket_i (decodedPacket_i),
    .dispWidth_i     (dispWidth_i),
    .partialEn_i     (partialEn_i),
    .stallFetch_o    (stallFetch_o),
    .dispatchValid_o (dispatchValid_o),
    .decodedPacket_o (decodedPacket_o),
    .branchCount_o   (branchCount_o),
    .occupancy_o     (occupancy_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet of write lane `lane` in the write tagged `tag`; branch flag = lane odd.
  function automatic logic [31:0] pkt(input logic [7:0] tag, input logic [3:0] lane);
    return {lane[0], 15'h0, tag, 4'h0, lane};
  endfunction

  typedef struct {
    logic       rdy;
    logic [7:0] vec;
    logic [7:0] tag;
    logic       flush;
    logic       stall;
    logic [2:0] dw;
    logic       part;
    logic       rstn;
    logic       eStall;
    logic [3:0] eValid;
    logic [2:0] eBc;
    logic [5:0] eOcc;
    logic [31:0] eTags;
    logic [15:0] eLanes;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic rdy, input logic [7:0] vec, input logic [7:0] tag,
                        input logic flush, input logic stall, input logic [2:0] dw,
                        input logic part, input logic rstn, input logic eStall,
                        input logic [3:0] eValid, input logic [2:0] eBc, input logic [5:0] eOcc,
                        input logic [31:0] eTags, input logic [15:0] eLanes);
    vec_t v;
    v.rdy = rdy; v.vec = vec; v.tag = tag; v.flush = flush; v.stall = stall;
    v.dw = dw; v.part = part; v.rstn = rstn; v.eStall = eStall; v.eValid = eValid;
    v.eBc = eBc; v.eOcc = eOcc; v.eTags = eTags; v.eLanes = eLanes;
    vecs.push_back(v);
  endtask

  // Driver: apply one cycle of inputs (called just after a falling edge).
  task automatic driveInputs(input logic rdy, input logic [7:0] vec, input logic [7:0] tag,
                             input logic flush, input logic stall, input logic [2:0] dw,
                             input logic part, input logic rstn);
    reset           = rstn;
    flush_i         = flush;
    stall_i         = stall;
    decodeReady_i   = rdy;
    decodedVector_i = vec;
    dispWidth_i     = dw;
    partialEn_i     = part;
    for (int i = 0; i < FW; i++) decodedPacket_i[i*PW +: PW] = pkt(tag, 4'(i));
  endtask

  // Scoreboard compare
  task automatic check(input string name, input int row, input logic [127:0] act,
                       input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [127:0] expPkts;
    vec_t v;

    // Reset state
    driveInputs(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    //     rdy vec    tag    fl   st   dw   pt   rn   eSt  eVal  eBc  eOcc  eTags          eLanes
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'hA5, 8'h01, 0, 0, 3'd4, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd4,  32'h01010101, 16'h7520);
    addRow(1, 8'h07, 8'h02, 0, 0, 3'd4, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'h0, 3'd0, 6'd3,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 1, 1,  0, 4'h7, 3'd1, 6'd3,  32'h00020202, 16'h0210);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 1, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'h2E, 8'h03, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd0, 1, 1,  0, 4'h0, 3'd0, 6'd4,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 1, 3'd4, 1, 1,  0, 4'h0, 3'd0, 6'd4,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd2, 0, 1,  0, 4'h3, 3'd1, 6'd4,  32'h00000303, 16'h0021);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd7, 1, 1,  0, 4'h3, 3'd2, 6'd2,  32'h00000303, 16'h0053);
    addRow(1, 8'hFF, 8'h04, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'hFF, 8'h05, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd8,  32'h0,        16'h0);
    addRow(1, 8'hFF, 8'h06, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd16, 32'h0,        16'h0);
    addRow(1, 8'h01, 8'h07, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd24, 32'h0,        16'h0);
    addRow(1, 8'hFF, 8'h08, 0, 0, 3'd0, 0, 1,  1, 4'h0, 3'd0, 6'd25, 32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  1, 4'hf, 3'd2, 6'd25, 32'h04040404, 16'h3210);
    addRow(1, 8'h03, 8'h09, 0, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd21, 32'h04040404, 16'h7654);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd19, 32'h05050505, 16'h3210);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd15, 32'h05050505, 16'h7654);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd3, 0, 1,  0, 4'h7, 3'd1, 6'd11, 32'h00060606, 16'h0210);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd8,  32'h06060606, 16'h6543);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd4,  32'h09090706, 16'h1007);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'h0F, 8'h0A, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'hFF, 8'h0B, 1, 0, 3'd4, 0, 1,  0, 4'hf, 3'd2, 6'd4,  32'h0a0a0a0a, 16'h3210);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 1, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'h02, 8'h0C, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 1, 1,  0, 4'h1, 3'd1, 6'd1,  32'h0000000c, 16'h0001);
    addRow(1, 8'hFF, 8'h0D, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'hFF, 8'h0E, 0, 0, 3'd4, 1, 0,  0, 4'hf, 3'd2, 6'd8,  32'h0d0d0d0d, 16'h3210);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd4, 1, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(1, 8'h80, 8'h0F, 0, 0, 3'd0, 0, 1,  0, 4'h0, 3'd0, 6'd0,  32'h0,        16'h0);
    addRow(0, 8'h00, 8'h00, 0, 0, 3'd1, 0, 1,  0, 4'h1, 3'd1, 6'd1,  32'h0000000f, 16'h0007);

    foreach (vecs[r]) begin
      v = vecs[r];
      @(negedge clk);
      driveInputs(v.rdy, v.vec, v.tag, v.flush, v.stall, v.dw, v.part, v.rstn);
      #1;
      expPkts = '0;
      for (int k = 0; k < DWD; k++) begin
        if (v.eValid[k]) expPkts[k*PW +: PW] = pkt(v.eTags[k*8 +: 8], v.eLanes[k*4 +: 4]);
      end
      check("stallFetch", r, 128'(stallFetch_o), 128'(v.eStall));
      check("dispatchValid", r, 128'(dispatchValid_o), 128'(v.eValid));
      check("branchCount", r, 128'(branchCount_o), 128'(v.eBc));
      check("occupancy", r, 128'(occupancy_o), 128'(v.eOcc));
      check("packets", r, decodedPacket_o, expPkts);
    end

    // Steady state: 4 written and 4 dispatched every cycle, occupancy holds at 4.
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j < 6) driveInputs(1'b1, 8'h0F, 8'(8'h20 + j), 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
      else       driveInputs(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
      #1;
      check("steady_occ", 100 + j, 128'(occupancy_o), (j == 0) ? 128'd0 : 128'd4);
      if (j > 0) begin
        expPkts = '0;
        for (int k = 0; k < DWD; k++) begin
          if (exp_q.size() > 0) expPkts[k*PW +: PW] = exp_q.pop_front();
        end
        check("steady_pkts", 100 + j, decodedPacket_o, expPkts);
      end
      if (j < 6) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(pkt(8'(8'h20 + j), 4'(i)));
      end
    end
    @(negedge clk);
    driveInputs(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
    #1;
    check("drained_occ", 107, 128'(occupancy_o), 128'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/param_inst_buffer.md
PARAM_INST_BUFFER -- requirements
Module: param_inst_buffer

Interface
REQ-001 Parameter FETCH_WIDTH, default 8: number of decoded-packet write lanes per cycle.
REQ-002 Parameter DISPATCH_WIDTH, default 4: number of read lanes per cycle.
REQ-003 Parameter DEPTH, default 32: queue entries; power of 2, at least 2*FETCH_WIDTH.
REQ-004 Parameter PKT_W, default taken from the package: decoded packet width in bits.
REQ-005 Parameter BR_BIT, default taken from the package: bit index of the branch flag inside a packet.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 flush_i  in  1  misprediction flush; empties the queue.
REQ-009 stall_i  in  1  backend stall; no dispatch this cycle.
REQ-010 decodeReady_i  in  1  write lanes carry valid data this cycle.
REQ-011 decodedVector_i  in  FETCH_WIDTH  per-lane valid bits; may be sparse.
REQ-012 decodedPacket_i  in  FETCH_WIDTH*PKT_W  lane-packed write packets; lane 0 = oldest.
REQ-013 dispWidth_i  in  clog2(DISPATCH_WIDTH)+1  runtime dispatch width.
REQ-014 partialEn_i  in  1  1 = partial-group dispatch allowed.
REQ-015 stallFetch_o  out  1  fetch stall.
REQ-016 dispatchValid_o  out  DISPATCH_WIDTH  per-lane dispatch valid; lane 0 = oldest.
REQ-017 decodedPacket_o  out  DISPATCH_WIDTH*PKT_W  dispatched packets.
REQ-018 branchCount_o  out  clog2(DISPATCH_WIDTH)+1  number of valid dispatched lanes with the branch flag set.
REQ-019 occupancy_o  out  clog2(DEPTH)+1  current entry count.

Function
REQ-020 Effective width W SHALL be min(dispWidth_i, DISPATCH_WIDTH); W=0 SHALL block dispatch.
REQ-021 Write acceptance: accept = decodeReady_i & ~stallFetch_o; when accept=0, no lane is written.
REQ-022 Accepted valid lanes SHALL be compacted in lane order into consecutive entries starting at tail; invalid lanes consume no entries.
REQ-023 tail SHALL advance by popcount(decodedVector_i) on accept, modulo DEPTH.
REQ-024 stallFetch_o SHALL be combinational: 1 when count > DEPTH-FETCH_WIDTH.
REQ-025 Dispatch count N: stall_i=1 or W=0 -> N=0; partialEn_i=0 -> N=W if count>=W, else 0; partialEn_i=1 -> N=min(count,W).
REQ-026 Read data SHALL be combinational from head..head+DISPATCH_WIDTH-1 modulo DEPTH; dispatchValid_o[k] = (k<N).
REQ-027 Lanes with k>=N SHALL drive all-zero packets.
REQ-028 Entries written in cycle t SHALL first be readable in cycle t+1; there is no write-to-read bypass.
REQ-029 At the clock edge, head SHALL advance by N and count SHALL update to count + written - N.
REQ-030 Simultaneous write and dispatch in one cycle SHALL both take effect.
REQ-031 Wrap-around of head and tail SHALL be seamless modulo DEPTH.
REQ-032 count SHALL never exceed DEPTH, which the stall threshold guarantees.
REQ-033 flush_i=1 SHALL set head, tail and count to 0 at the edge, overriding same-cycle writes and dispatch.
REQ-034 While flush_i=1, outputs still reflect the pre-flush state.
REQ-035 branchCount_o SHALL sum bit BR_BIT of the valid dispatched lanes only.

Reset
REQ-036 reset=0 at an edge SHALL clear head, tail and count; it has the same priority as flush and applies mid-operation.
REQ-037 After reset: stallFetch_o=0, dispatchValid_o=0, decodedPacket_o=0, branchCount_o=0, occupancy_o=0.
REQ-038 Storage array contents need no reset.

Structure
REQ-039 The shared package SHALL hold PKT_W, BR_BIT, the packet field offsets and the default widths.
REQ-040 Storage SHALL be one sub-module, ib_ram: DEPTH x PKT_W, FETCH_WIDTH write ports, DISPATCH_WIDTH combinational read ports.
REQ-041 Compaction, pointers, count and dispatch control SHALL live in param_inst_buffer.

Verification
REQ-042 Sparse write: decodedVector_i=8'b1010_0101, empty queue, W=4, partialEn_i=0 -> next cycle occupancy_o=4, lanes 0-3 = packets from write lanes 0,2,5,7, dispatchValid_o=4'b1111.
REQ-043 Partial dispatch: 3 entries, W=4 -> partialEn_i=0 gives dispatchValid_o=0; partialEn_i=1 gives 4'b0111, then occupancy_o=0.
REQ-044 Full/stall: DEPTH=32, fill to 25 -> stallFetch_o=1 and a write with all 8 lanes valid is dropped (occupancy_o stays 25); dispatch 4 -> stallFetch_o=0.
REQ-045 Wrap: head=30, tail=2, 4 entries, W=4 -> reads entries 30,31,0,1 in order; head becomes 2.
REQ-046 Flush and reset: flush_i=1 together with 8 writes and a dispatch -> occupancy_o=0 next cycle; reset=0 mid-stream -> all outputs are at their reset values next cycle.
REQ-047 Branch count: 4 dispatched lanes with branch flags 1,0,1,1 and W=2 -> branchCount_o=1 and dispatchValid_o=4'b0011.
